// File: rtl/pt22xx_pkg.sv
// Shared types and widths for the PT2272 decoder back end.
package pt22xx_pkg;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {MODE_MOM, MODE_LATCH, MODE_TOGGLE} mode_e;
    typedef enum logic [1:0] {IDLE, QUALIFY, ACTIVE} state_e;

endpackage

// File: rtl/pt2272_output_stage_if.sv
// Decoded-word bus from the PT2272 decoder into the output stage.
interface pt2272_output_stage_if;
    import pt22xx_pkg::*;

    logic [DATA_W-1:0] D;
    logic              dv;

    modport master (output D, dv);
    modport slave  (input  D, dv);

endinterface

// File: rtl/pt22xx_hold_timer.sv
// Inter-word hold timer: reloads on each decoded word and flags the end of a transmission.
module pt22xx_hold_timer #(
    parameter int HOLD_CYCLES = 60000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expired,
    output logic busy
);

    localparam int            TW     = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0] RELOAD = TW'(HOLD_CYCLES);

    logic [TW-1:0] timer;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (load) begin
            timer <= RELOAD;
        end else if (timer != '0) begin
            timer <= timer - 1'b1;
        end
    end

    // A word arriving on the last count reloads the timer instead of ending the transmission.
    assign busy    = (timer != '0);
    assign expired = (timer == TW'(1)) && !load;

endmodule

// File: rtl/pt2272_output_stage.sv
// PT2272 output stage: qualifies repeated words and drives Q/vt/strobe in momentary, latch or toggle flavour.
module pt2272_output_stage
    import pt22xx_pkg::*;
#(
    parameter int MODE        = 0,
    parameter int MIN_WORDS   = 2,
    parameter int HOLD_CYCLES = 60000
) (
    input  logic                  clk,
    input  logic                  reset,
    pt2272_output_stage_if.slave  dec,
    output logic [DATA_W-1:0]     Q,
    output logic                  vt,
    output logic                  strobe
);

    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_WORDS);

    state_e            state, state_next;
    logic [DATA_W-1:0] cand, cand_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [DATA_W-1:0] q_next;
    logic              entry;
    logic              expired;
    logic              timer_busy_unused;

    pt22xx_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (dec.dv),
        .expired (expired),
        .busy    (timer_busy_unused)
    );

    // entry marks every transition into ACTIVE, including the MIN_WORDS==1 re-entry on a new word.
    always_comb begin
        state_next = state;
        cand_next  = cand;
        cnt_next   = cnt;
        entry      = 1'b0;
        case (state)
            IDLE: begin
                if (dec.dv) begin
                    cand_next = dec.D;
                    cnt_next  = CNT_W'(1);
                    if (MIN_CNT == CNT_W'(1)) begin
                        state_next = ACTIVE;
                        entry      = 1'b1;
                    end else begin
                        state_next = QUALIFY;
                    end
                end
            end
            QUALIFY: begin
                if (dec.dv) begin
                    if (dec.D == cand) begin
                        if (cnt + 1'b1 >= MIN_CNT) begin
                            state_next = ACTIVE;
                            cnt_next   = MIN_CNT;
                            entry      = 1'b1;
                        end else begin
                            cnt_next = cnt + 1'b1;
                        end
                    end else begin
                        cand_next = dec.D;
                        cnt_next  = CNT_W'(1);
                    end
                end else if (expired) begin
                    state_next = IDLE;
                end
            end
            ACTIVE: begin
                if (dec.dv) begin
                    if (dec.D != cand) begin
                        cand_next = dec.D;
                        cnt_next  = CNT_W'(1);
                        if (MIN_CNT == CNT_W'(1)) begin
                            entry = 1'b1;
                        end else begin
                            state_next = QUALIFY;
                        end
                    end
                end else if (expired) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        q_next = Q;
        if (MODE == int'(MODE_MOM)) begin
            q_next = (state_next == ACTIVE) ? cand_next : '0;
        end else if (MODE == int'(MODE_LATCH)) begin
            if (entry) q_next = cand_next;
        end else if (MODE == int'(MODE_TOGGLE)) begin
            if (entry) q_next = Q ^ cand_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cand   <= '0;
            cnt    <= '0;
            Q      <= '0;
            vt     <= 1'b0;
            strobe <= 1'b0;
        end else begin
            state  <= state_next;
            cand   <= cand_next;
            cnt    <= cnt_next;
            Q      <= q_next;
            vt     <= (state_next == ACTIVE);
            strobe <= entry;
        end
    end

endmodule

// File: tb/tb_pt2272_output_stage.sv
// Directed bench: momentary, latch and toggle instances share one decoder bus and are checked side by side.
module tb_pt2272_output_stage;
    import pt22xx_pkg::*;

    logic       clk;
    logic       reset;
    logic [3:0] q_mom, q_lat, q_tog;
    logic       vt_mom, vt_lat, vt_tog;
    logic       strobe_mom, strobe_lat, strobe_tog;
    int         checks = 0;
    int         errors = 0;

    pt2272_output_stage_if bus ();

    pt2272_output_stage #(.MODE(0), .MIN_WORDS(2), .HOLD_CYCLES(100)) dut_mom (
        .clk(clk), .reset(reset), .dec(bus), .Q(q_mom), .vt(vt_mom), .strobe(strobe_mom)
    );
    pt2272_output_stage #(.MODE(1), .MIN_WORDS(2), .HOLD_CYCLES(100)) dut_lat (
        .clk(clk), .reset(reset), .dec(bus), .Q(q_lat), .vt(vt_lat), .strobe(strobe_lat)
    );
    pt2272_output_stage #(.MODE(2), .MIN_WORDS(2), .HOLD_CYCLES(100)) dut_tog (
        .clk(clk), .reset(reset), .dec(bus), .Q(q_tog), .vt(vt_tog), .strobe(strobe_tog)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %b expected %b", tag, observed, expected);
        end
    endtask

    // One dv pulse; returns 1 ns after the edge that captured it, so outputs show the response.
    task automatic applyStimulus(input logic [3:0] d);
        bus.D  = d;
        bus.dv = 1'b1;
        @(posedge clk);
        #1;
        bus.dv = 1'b0;
        bus.D  = 4'b0000;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.D  = 4'b0000;
        bus.dv = 1'b0;
        reset  = 1'b0;
        waitCycles(2);

        // Words during reset are lost
        applyStimulus(4'b1011);
        checkOutput("rst_vt_a", vt_mom, 4'b0);
        checkOutput("rst_q_mom_a", q_mom, 4'b0000);
        checkOutput("rst_strobe_a", strobe_mom, 4'b0);
        applyStimulus(4'b1011);
        checkOutput("rst_vt_b", vt_lat, 4'b0);
        checkOutput("rst_q_lat_b", q_lat, 4'b0000);
        checkOutput("rst_q_tog_b", q_tog, 4'b0000);
        reset = 1'b1;
        waitCycles(2);
        applyStimulus(4'b1011);
        checkOutput("rst_one_word_vt", vt_mom, 4'b0);
        waitCycles(110);

        // Momentary qualification and timeout
        applyStimulus(4'b1011);
        waitCycles(39);
        checkOutput("mom_first_vt", vt_mom, 4'b0);
        applyStimulus(4'b1011);
        checkOutput("mom_vt", vt_mom, 4'b1);
        checkOutput("mom_q", q_mom, 4'b1011);
        checkOutput("mom_strobe", strobe_mom, 4'b1);
        checkOutput("lat_q_first", q_lat, 4'b1011);
        checkOutput("tog_q_first", q_tog, 4'b1011);
        waitCycles(1);
        checkOutput("mom_strobe_once", strobe_mom, 4'b0);
        checkOutput("mom_q_hold", q_mom, 4'b1011);
        waitCycles(98);
        checkOutput("mom_vt_last", vt_mom, 4'b1);
        waitCycles(1);
        checkOutput("mom_vt_drop", vt_mom, 4'b0);
        checkOutput("mom_q_drop", q_mom, 4'b0000);
        checkOutput("lat_q_held", q_lat, 4'b1011);
        checkOutput("tog_q_held", q_tog, 4'b1011);

        // Latch picks up a new word
        waitCycles(20);
        applyStimulus(4'b0100);
        waitCycles(39);
        applyStimulus(4'b0100);
        checkOutput("lat_q_new", q_lat, 4'b0100);
        checkOutput("mom_q_new", q_mom, 4'b0100);
        checkOutput("tog_q_new", q_tog, 4'b1111);
        waitCycles(110);
        checkOutput("lat_vt_end", vt_lat, 4'b0);
        checkOutput("lat_q_end", q_lat, 4'b0100);
        checkOutput("mom_q_end", q_mom, 4'b0000);

        // Mismatch restarts qualification
        applyStimulus(4'b1011);
        waitCycles(39);
        applyStimulus(4'b0011);
        checkOutput("mis_vt_second", vt_mom, 4'b0);
        waitCycles(39);
        applyStimulus(4'b0011);
        checkOutput("mis_vt_third", vt_mom, 4'b1);
        checkOutput("mis_q_mom", q_mom, 4'b0011);
        checkOutput("mis_q_lat", q_lat, 4'b0011);
        checkOutput("mis_strobe_lat", strobe_lat, 4'b1);
        checkOutput("mis_q_tog", q_tog, 4'b1100);
        waitCycles(110);

        // Toggle sessions from a cleared Q
        reset = 1'b0;
        #1;
        checkOutput("tog_async_clr", q_tog, 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        waitCycles(2);
        applyStimulus(4'b1001);
        waitCycles(10);
        applyStimulus(4'b1001);
        checkOutput("tog_a_q", q_tog, 4'b1001);
        checkOutput("tog_a_strobe", strobe_tog, 4'b1);
        waitCycles(10);
        applyStimulus(4'b1001);
        checkOutput("tog_a_extra_q", q_tog, 4'b1001);
        checkOutput("tog_a_extra_strobe", strobe_tog, 4'b0);
        waitCycles(110);
        checkOutput("tog_a_vt_end", vt_tog, 4'b0);
        checkOutput("tog_a_q_end", q_tog, 4'b1001);
        applyStimulus(4'b1001);
        waitCycles(10);
        applyStimulus(4'b1001);
        checkOutput("tog_b_q", q_tog, 4'b0000);
        checkOutput("tog_b_vt", vt_tog, 4'b1);
        waitCycles(110);
        applyStimulus(4'b0011);
        waitCycles(10);
        applyStimulus(4'b0011);
        checkOutput("tog_c_q", q_tog, 4'b0011);
        waitCycles(110);

        // dv on the expiry cycle keeps the session alive
        applyStimulus(4'b1011);
        waitCycles(10);
        applyStimulus(4'b1011);
        waitCycles(99);
        checkOutput("exp_vt_before", vt_mom, 4'b1);
        applyStimulus(4'b1011);
        checkOutput("exp_vt_kept", vt_mom, 4'b1);
        checkOutput("exp_no_strobe", strobe_mom, 4'b0);
        waitCycles(50);
        checkOutput("exp_vt_later", vt_mom, 4'b1);

        // Asynchronous reset mid-ACTIVE in latch mode
        checkOutput("lat_pre_rst_q", q_lat, 4'b1011);
        checkOutput("lat_pre_rst_vt", vt_lat, 4'b1);
        reset = 1'b0;
        #2;
        checkOutput("lat_rst_q", q_lat, 4'b0000);
        checkOutput("lat_rst_vt", vt_lat, 4'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        waitCycles(2);
        applyStimulus(4'b1011);
        checkOutput("lat_requal_vt1", vt_lat, 4'b0);
        checkOutput("lat_requal_q1", q_lat, 4'b0000);
        waitCycles(10);
        applyStimulus(4'b1011);
        checkOutput("lat_requal_vt2", vt_lat, 4'b1);
        checkOutput("lat_requal_q2", q_lat, 4'b1011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
